// File: rtl/mdio_slave_if.sv
`default_nettype none
// ----------------------------------------------------------------
// mdio_slave_if : MDIO strobe/bit bus plus register-file handshake
// Rev 1.0
// ----------------------------------------------------------------
interface mdio_slave_if;
  logic        ce;
  logic        mdi;
  logic        mdo;
  logic        mdo_valid;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_read;
  logic        reg_write;
  logic [15:0] reg_rdata;
  logic        reg_ack;
  logic        reg_err;

  modport slave (
    input  ce, mdi, reg_rdata, reg_ack, reg_err,
    output mdo, mdo_valid, reg_addr, reg_wdata, reg_read, reg_write
  );

  modport master (
    output ce, mdi, reg_rdata, reg_ack, reg_err,
    input  mdo, mdo_valid, reg_addr, reg_wdata, reg_read, reg_write
  );
endinterface
`default_nettype wire

// File: rtl/mdio_slave.sv
`default_nettype none
// ----------------------------------------------------------------
// mdio_slave : clause-22 MDIO frame parser and register sequencer
// Rev 1.0
// ----------------------------------------------------------------
module mdio_slave #(
  parameter logic [4:0] ADDRESS = 5'd0
) (
  input  logic         clk,
  input  logic         rst,
  mdio_slave_if.slave  bus
);

  typedef enum logic [2:0] {
    S_PREAMBLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA1, S_TA2, S_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  ones_q, ones_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        op0_q, op0_d;
  logic        is_read_q, is_read_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        reg_read_q, reg_read_d;
  logic        reg_write_q, reg_write_d;
  logic        rd_ok_q, rd_ok_d;
  logic        mdo_q, mdo_d;
  logic        mdo_valid_q, mdo_valid_d;

  logic [4:0]  regad_full;
  logic [15:0] shift_in;

  assign regad_full = {regad_q[3:0], bus.mdi};
  assign shift_in   = {shift_q[14:0], bus.mdi};

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    bitcnt_d    = bitcnt_q;
    op0_d       = op0_q;
    is_read_d   = is_read_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    reg_addr_d  = reg_addr_q;
    shift_d     = shift_q;
    reg_wdata_d = reg_wdata_q;
    reg_read_d  = reg_read_q;
    reg_write_d = reg_write_q;
    rd_ok_d     = rd_ok_q;
    mdo_d       = mdo_q;
    mdo_valid_d = mdo_valid_q;

    // Handshake completion is tracked every clk, independent of ce.
    if (reg_read_q && (bus.reg_ack || bus.reg_err)) begin
      reg_read_d = 1'b0;
      if (bus.reg_ack) begin
        rd_ok_d = 1'b1;
        shift_d = bus.reg_rdata;
      end
    end
    if (reg_write_q && (bus.reg_ack || bus.reg_err)) begin
      reg_write_d = 1'b0;
    end

    if (bus.ce) begin
      case (state_q)
        S_PREAMBLE: begin
          if (bus.mdi) begin
            if (ones_q < 6'd32) ones_d = ones_q + 6'd1;
          end else if (ones_q >= 6'd32) begin
            state_d = S_ST2;
            ones_d  = 6'd0;
          end else begin
            ones_d = 6'd0;
          end
        end
        S_ST2: begin
          bitcnt_d = 4'd0;
          state_d  = bus.mdi ? S_OP : S_PREAMBLE;
        end
        S_OP: begin
          op0_d    = bus.mdi;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd1) begin
            bitcnt_d = 4'd0;
            if (op0_q != bus.mdi) begin
              is_read_d = op0_q;
              state_d   = S_PHYAD;
            end else begin
              state_d = S_PREAMBLE;
            end
          end
        end
        S_PHYAD: begin
          phyad_d  = {phyad_q[3:0], bus.mdi};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd4) begin
            bitcnt_d = 4'd0;
            state_d  = S_REGAD;
          end
        end
        S_REGAD: begin
          regad_d  = regad_full;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd4) begin
            bitcnt_d = 4'd0;
            if (phyad_q != ADDRESS) begin
              state_d = S_PREAMBLE;
            end else if (is_read_q) begin
              // A read cannot overlap a still-pending write; drop the frame.
              if (reg_write_d) begin
                state_d = S_PREAMBLE;
              end else begin
                reg_read_d = 1'b1;
                reg_addr_d = regad_full;
                rd_ok_d    = 1'b0;
                state_d    = S_TA1;
              end
            end else begin
              state_d = S_TA1;
            end
          end
        end
        S_TA1: begin
          if (is_read_q) begin
            reg_read_d = 1'b0;
            if (rd_ok_d) begin
              mdo_valid_d = 1'b1;
              mdo_d       = 1'b0;
              state_d     = S_TA2;
            end else begin
              state_d = S_PREAMBLE;
            end
          end else begin
            state_d = S_TA2;
          end
        end
        S_TA2: begin
          bitcnt_d = 4'd0;
          state_d  = S_DATA;
          if (is_read_q) begin
            mdo_d   = shift_q[15];
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
        S_DATA: begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (is_read_q) begin
            if (bitcnt_q == 4'd15) begin
              mdo_valid_d = 1'b0;
              mdo_d       = 1'b1;
              state_d     = S_PREAMBLE;
            end else begin
              mdo_d   = shift_q[15];
              shift_d = {shift_q[14:0], 1'b0};
            end
          end else begin
            shift_d = shift_in;
            if (bitcnt_q == 4'd15) begin
              state_d = S_PREAMBLE;
              if (!reg_write_d && !reg_read_d) begin
                reg_write_d = 1'b1;
                reg_wdata_d = shift_in;
                reg_addr_d  = regad_q;
              end
            end
          end
        end
        default: state_d = S_PREAMBLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PREAMBLE;
      ones_q      <= 6'd0;
      bitcnt_q    <= 4'd0;
      op0_q       <= 1'b0;
      is_read_q   <= 1'b0;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      reg_addr_q  <= 5'd0;
      shift_q     <= 16'd0;
      reg_wdata_q <= 16'd0;
      reg_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      rd_ok_q     <= 1'b0;
      mdo_q       <= 1'b1;
      mdo_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      bitcnt_q    <= bitcnt_d;
      op0_q       <= op0_d;
      is_read_q   <= is_read_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      reg_addr_q  <= reg_addr_d;
      shift_q     <= shift_d;
      reg_wdata_q <= reg_wdata_d;
      reg_read_q  <= reg_read_d;
      reg_write_q <= reg_write_d;
      rd_ok_q     <= rd_ok_d;
      mdo_q       <= mdo_d;
      mdo_valid_q <= mdo_valid_d;
    end
  end

  assign bus.mdo       = mdo_q;
  assign bus.mdo_valid = mdo_valid_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_read  = reg_read_q;
  assign bus.reg_write = reg_write_q;

endmodule
`default_nettype wire
